// File: rtl/mlp_binary_classifier_if.sv
// Handshake and weight-write bundle for mlp_binary_classifier.
// Master drives samples, weights and result_rdy; slave is the engine.
interface mlp_binary_classifier_if #(
  parameter int INPUTS_NUM = 3,
  parameter int AW         = 6,
  parameter int W          = 20
);
  logic                  in_data_vld;
  logic                  in_data_rdy;
  logic [INPUTS_NUM-1:0] in_data;
  logic                  wgt_wr_en;
  logic [AW-1:0]         wgt_wr_addr;
  logic [W-1:0]          wgt_wr_data;
  logic                  wgt_wr_rdy;
  logic                  result_data;
  logic                  result_vld;
  logic                  result_rdy;

  modport master (
    output in_data_vld, in_data,
    output wgt_wr_en, wgt_wr_addr, wgt_wr_data,
    output result_rdy,
    input  in_data_rdy, wgt_wr_rdy,
    input  result_data, result_vld
  );

  modport slave (
    input  in_data_vld, in_data,
    input  wgt_wr_en, wgt_wr_addr, wgt_wr_data,
    input  result_rdy,
    output in_data_rdy, wgt_wr_rdy,
    output result_data, result_vld
  );
endinterface

// File: rtl/mlp_binary_classifier.sv
// Single-hidden-layer fixed-point MLP over one time-shared MAC.
// Binary inputs, runtime-loaded weights, binary decision output.
module mlp_binary_classifier #(
  parameter int INPUTS_NUM = 3,
  parameter int HIDDEN_NUM = 9,
  parameter int FXP_INT    = 6,
  parameter int FXP_FRAC   = 14,
  localparam int W  = FXP_INT + FXP_FRAC,
  localparam int NW = HIDDEN_NUM*(INPUTS_NUM+2)+1,
  localparam int AW = $clog2(NW)
) (
  input logic clk,
  input logic rst,
  mlp_binary_classifier_if.slave bus
);
  localparam int MAXN = (INPUTS_NUM > HIDDEN_NUM) ? INPUTS_NUM : HIDDEN_NUM;
  localparam int ACCW = W + $clog2(MAXN+1) + 1;
  localparam int IW   = $clog2(INPUTS_NUM+1);
  localparam int JW   = $clog2(HIDDEN_NUM+1);
  localparam int PW   = 2*W;
  localparam logic signed [ACCW:0] SAT_MAX =
    (ACCW+1)'((64'sd1 <<< (W-1)) - 64'sd1);

  typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

  state_t state_q, state_d;

  logic [NW-1:0][W-1:0]         w_q;
  logic [HIDDEN_NUM-1:0][W-1:0] h_q;
  logic [HIDDEN_NUM-1:0][W-1:0] h_nx;
  logic signed [ACCW-1:0]       acc_q;
  logic [INPUTS_NUM-1:0]        x_q;
  logic [IW-1:0]                i_q;
  logic [JW-1:0]                cnt_q;
  logic [AW-1:0]                ra_q;
  logic                         res_q;

  logic                   idle;
  logic                   wr_ok;
  logic                   last_i;
  logic                   last_j;
  logic                   last_k;
  logic                   h_shift;
  logic signed [W-1:0]    w_rd;
  logic signed [W-1:0]    h_in;
  logic signed [ACCW:0]   sum;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] term;

  assign idle   = (state_q == IDLE);
  assign last_i = (i_q == IW'(INPUTS_NUM));
  assign last_j = (cnt_q == JW'(HIDDEN_NUM-1));
  assign last_k = (cnt_q == JW'(HIDDEN_NUM));
  assign wr_ok  = bus.wgt_wr_en && idle &&
                  (32'(bus.wgt_wr_addr) < NW);

  assign bus.in_data_rdy = idle;
  assign bus.wgt_wr_rdy  = idle;
  assign bus.result_vld  = (state_q == DONE);
  assign bus.result_data = res_q;

  // The read pointer walks the weight map linearly: hidden rows, then
  // output weights, ending on the output bias.
  assign w_rd = $signed(w_q[ra_q]);
  assign sum  = (ACCW+1)'(acc_q) + (ACCW+1)'(w_rd);
  assign prod = PW'(w_rd) * PW'($signed(h_q[0]));
  assign term = ACCW'(prod >>> FXP_FRAC);

  always_comb begin
    h_in = '0;
    if (state_q == OUT) begin
      h_in = $signed(h_q[0]);
    end else if (sum > SAT_MAX) begin
      h_in = SAT_MAX[W-1:0];
    end else if (sum > 0) begin
      h_in = sum[W-1:0];
    end
    h_shift = ((state_q == HID) && last_i) ||
              ((state_q == OUT) && !last_k);
    h_nx = h_q >> W;
    h_nx[HIDDEN_NUM-1] = h_in;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_data_vld) state_d = HID;
      HID:  if (last_i && last_j) state_d = OUT;
      OUT:  if (last_k) state_d = DONE;
      DONE: if (bus.result_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q   <= '0;
      h_q   <= '0;
      acc_q <= '0;
      x_q   <= '0;
      i_q   <= '0;
      cnt_q <= '0;
      ra_q  <= '0;
      res_q <= 1'b0;
    end else begin
      if (wr_ok) w_q[bus.wgt_wr_addr] <= bus.wgt_wr_data;
      if (h_shift) h_q <= h_nx;
      unique case (state_q)
        IDLE: if (bus.in_data_vld) begin
          x_q   <= bus.in_data;
          acc_q <= '0;
          i_q   <= '0;
          cnt_q <= '0;
          ra_q  <= '0;
        end
        HID: begin
          ra_q <= ra_q + 1'b1;
          if (!last_i) begin
            acc_q <= acc_q + (x_q[0] ? ACCW'(w_rd) : '0);
            x_q   <= (x_q >> 1) | (x_q << (INPUTS_NUM-1));
            i_q   <= i_q + 1'b1;
          end else begin
            acc_q <= '0;
            i_q   <= '0;
            cnt_q <= last_j ? '0 : cnt_q + 1'b1;
          end
        end
        OUT: begin
          if (!last_k) begin
            acc_q <= acc_q + term;
            cnt_q <= cnt_q + 1'b1;
            ra_q  <= ra_q + 1'b1;
          end else begin
            res_q <= (sum > 0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mlp_binary_classifier.sv
// Randomised and directed bench for mlp_binary_classifier.
// Reference model evaluates the network with plain integer arithmetic.
module tb_mlp_binary_classifier;
  localparam int I  = 3;
  localparam int H  = 9;
  localparam int FI = 6;
  localparam int FF = 14;
  localparam int W  = FI + FF;
  localparam int NW = H*(I+2)+1;
  localparam int AW = $clog2(NW);
  localparam int L  = H*(I+2)+2;
  localparam int VA = H*(I+1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mlp_binary_classifier_if #(.INPUTS_NUM(I), .AW(AW), .W(W)) bus();

  mlp_binary_classifier #(
    .INPUTS_NUM(I), .HIDDEN_NUM(H),
    .FXP_INT(FI), .FXP_FRAC(FF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  longint wm [NW];

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(longint v);
    longint m;
    m = v & ((64'sd1 <<< W) - 1);
    if (m >= (64'sd1 <<< (W-1))) m -= (64'sd1 <<< W);
    return m;
  endfunction

  function automatic bit model(logic [I-1:0] x);
    longint h [H];
    longint acc;
    longint hi = (64'sd1 <<< (W-1)) - 1;
    longint lo = -(64'sd1 <<< (W-1));
    for (int j = 0; j < H; j++) begin
      acc = 0;
      for (int i = 0; i < I; i++)
        if (x[i]) acc += wm[j*(I+1)+i];
      acc += wm[j*(I+1)+I];
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
      h[j] = (acc < 0) ? 0 : acc;
    end
    acc = 0;
    for (int j = 0; j < H; j++)
      acc += (wm[VA+j] * h[j]) >>> FF;
    acc += wm[NW-1];
    return acc > 0;
  endfunction

  task automatic clear_model();
    for (int a = 0; a < NW; a++) wm[a] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    check("rst_in_rdy", bus.in_data_rdy, 1);
    check("rst_wr_rdy", bus.wgt_wr_rdy, 1);
    check("rst_vld", bus.result_vld, 0);
    check("rst_data", bus.result_data, 0);
  endtask

  task automatic wr(int addr, longint val);
    bus.wgt_wr_en   = 1'b1;
    bus.wgt_wr_addr = AW'(addr);
    bus.wgt_wr_data = val[W-1:0];
    @(posedge clk);
    #1 bus.wgt_wr_en = 1'b0;
    if (addr < NW) wm[addr] = sx(val);
  endtask

  task automatic run(logic [I-1:0] x, int bp, bit pre, bit busy,
                     longint bval, bit pulse, output bit got);
    bit exp;
    int n;
    int bad;
    logic d;
    exp = model(x);
    check("pre_in_rdy", bus.in_data_rdy, 1);
    bus.in_data     = x;
    bus.in_data_vld = 1'b1;
    bus.result_rdy  = pre;
    @(posedge clk);
    #1;
    bus.in_data_vld = 1'b0;
    bus.in_data     = ~x;
    n   = 1;
    bad = 0;
    forever begin
      if (bus.result_vld || n > L+10) break;
      if (bus.in_data_rdy) bad++;
      if (busy && n == 5) begin
        check("busy_wr_rdy", bus.wgt_wr_rdy, 0);
        bus.wgt_wr_en   = 1'b1;
        bus.wgt_wr_addr = AW'(VA);
        bus.wgt_wr_data = bval[W-1:0];
      end
      if (n == 6) bus.wgt_wr_en = 1'b0;
      @(posedge clk);
      #1 n++;
    end
    bus.wgt_wr_en = 1'b0;
    got = bus.result_data;
    check("latency", n, L);
    check("busy_in_rdy", bad, 0);
    check("result", got, exp);
    if (n > L+10) return;
    if (pre) begin
      @(posedge clk);
      #1 bus.result_rdy = 1'b0;
    end else begin
      d   = bus.result_data;
      bad = 0;
      for (int c = 0; c < bp; c++) begin
        if (pulse && c == 2) bus.in_data_vld = 1'b1;
        @(posedge clk);
        #1 bus.in_data_vld = 1'b0;
        if (!bus.result_vld || bus.result_data !== d) bad++;
        if (bus.in_data_rdy) bad++;
      end
      if (bp > 0) check("bp_stable", bad, 0);
      bus.result_rdy = 1'b1;
      @(posedge clk);
      #1 bus.result_rdy = 1'b0;
    end
    check("post_vld", bus.result_vld, 0);
    check("post_in_rdy", bus.in_data_rdy, 1);
  endtask

  task automatic majority();
    wr(0, 16384);
    wr(1, 16384);
    wr(2, 16384);
    wr(3, -8192);
    wr(VA, 16384);
    wr(NW-1, -16384);
  endtask

  initial begin
    bit got;
    int vs;
    bus.in_data_vld = 1'b0;
    bus.in_data     = '0;
    bus.wgt_wr_en   = 1'b0;
    bus.wgt_wr_addr = '0;
    bus.wgt_wr_data = '0;
    bus.result_rdy  = 1'b0;
    @(posedge clk);
    #1 do_reset();

    run(3'b101, 0, 0, 0, 0, 0, got);
    check("zero_net", got, 0);

    majority();
    run(3'b110, 0, 0, 0, 0, 0, got);
    check("maj_110", got, 1);
    run(3'b100, 0, 1, 0, 0, 0, got);
    check("maj_100", got, 0);
    run(3'b000, 0, 0, 0, 0, 0, got);
    check("maj_000", got, 0);
    run(3'b110, 10, 0, 0, 0, 1, got);
    check("maj_bp", got, 1);

    run(3'b110, 0, 0, 1, -16384, 0, got);
    check("busy_ignored", got, 1);
    wr(VA, -16384);
    run(3'b110, 0, 0, 0, 0, 0, got);
    check("idle_write", got, 0);
    wr(NW, 16384);
    run(3'b110, 0, 0, 0, 0, 0, got);
    check("oob_write", got, 0);

    do_reset();
    for (int a = 0; a < 4; a++) wr(a, 'h7FFFF);
    wr(VA, 16384);
    wr(NW-1, -16384);
    run(3'b111, 0, 0, 0, 0, 0, got);
    check("sat_hi", got, 1);
    wr(3, 'h80000);
    run(3'b000, 0, 0, 0, 0, 0, got);
    check("relu_lo", got, 0);

    do_reset();
    majority();
    bus.in_data     = 3'b110;
    bus.in_data_vld = 1'b1;
    @(posedge clk);
    #1 bus.in_data_vld = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    check("midrst_in_rdy", bus.in_data_rdy, 1);
    vs = 0;
    repeat (60) begin
      @(posedge clk);
      #1 if (bus.result_vld) vs++;
    end
    check("midrst_no_vld", vs, 0);
    run(3'b110, 0, 0, 0, 0, 0, got);
    check("midrst_cleared", got, 0);

    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(6, 1))
        wr($urandom_range(NW),
           longint'($urandom_range(65534)) - 32767);
      run(I'($urandom_range(7)), $urandom_range(3),
          1'($urandom_range(1)), 1'($urandom_range(1)),
          longint'($urandom_range(65534)) - 32767,
          1'($urandom_range(1)), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
